// File: rtl/common_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// Module   : common (package)
// Purpose  : Shared scalar types and divider FSM state encoding.
// Revision : 1.0
// =====================================================================
package common;
    typedef logic [63:0] u64;
    typedef logic [1:0]  u2;

    typedef enum u2 {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int WORD_BITS = 32;
endpackage
`default_nettype wire

// File: rtl/div_step.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// Module   : div_step
// Purpose  : One restoring radix-2 iteration (shift, trial-subtract).
// Revision : 1.0
// =====================================================================
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_remNext,
    output logic [XLEN-1:0] o_quoNext
);
    logic [XLEN:0]   w_shifted;
    logic [XLEN-1:0] w_sub;
    logic            w_ge;

    always_comb begin
        w_shifted = {i_rem, i_quo[XLEN-1]};
        w_ge      = (w_shifted >= {1'b0, i_divisor});
        // When the trial succeeds the difference is below the divisor, so XLEN bits suffice.
        w_sub     = w_shifted[XLEN-1:0] - i_divisor;
        o_remNext = w_ge ? w_sub : w_shifted[XLEN-1:0];
        o_quoNext = {i_quo[XLEN-2:0], w_ge};
    end
endmodule
`default_nettype wire

// File: rtl/div_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// Module   : div_ctrl
// Purpose  : Multi-cycle signed/unsigned divide/remainder with stall.
// Revision : 1.0
// =====================================================================
module div_ctrl
    import common::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            flush,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            sign,
    input  logic            want_rem,
    input  logic            cut,
    output logic            e_wait,
    output logic            done,
    output logic [XLEN-1:0] c
);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] c_fullIters = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] c_wordIters = CNT_W'(WORD_BITS);

    div_state_t      r_state, w_nextState;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0] r_rem, r_quo, r_div, r_result;
    logic            r_negQ, r_negR, r_wantRem, r_cut;

    logic [XLEN-1:0] w_aExt, w_bExt, w_aAbs, w_bAbs, w_quoLoad, w_minNeg;
    logic [XLEN-1:0] w_specialResult, w_fixResult, w_stepRem, w_stepQuo;
    logic            w_aNeg, w_bNeg, w_divZero, w_overflow;

    function automatic logic [XLEN-1:0] fitWord(input logic [XLEN-1:0] val, input logic isWord);
        return isWord ? {{(XLEN-WORD_BITS){val[WORD_BITS-1]}}, val[WORD_BITS-1:0]} : val;
    endfunction

    // Operand preparation: word ops are widened first, then everything works on magnitudes.
    always_comb begin
        if (cut) begin
            w_aExt = {{(XLEN-WORD_BITS){sign & a[WORD_BITS-1]}}, a[WORD_BITS-1:0]};
            w_bExt = {{(XLEN-WORD_BITS){sign & b[WORD_BITS-1]}}, b[WORD_BITS-1:0]};
            w_minNeg = {{(XLEN-WORD_BITS+1){1'b1}}, {(WORD_BITS-1){1'b0}}};
        end else begin
            w_aExt = a;
            w_bExt = b;
            w_minNeg = {1'b1, {(XLEN-1){1'b0}}};
        end
        w_aNeg     = sign & w_aExt[XLEN-1];
        w_bNeg     = sign & w_bExt[XLEN-1];
        w_aAbs     = w_aNeg ? -w_aExt : w_aExt;
        w_bAbs     = w_bNeg ? -w_bExt : w_bExt;
        // A word dividend sits in the top bits so 32 shifts consume exactly its magnitude.
        w_quoLoad  = cut ? (w_aAbs << (XLEN - WORD_BITS)) : w_aAbs;
        w_divZero  = (w_bExt == '0);
        w_overflow = sign & (w_aExt == w_minNeg) & (&w_bExt);
        if (w_divZero)
            w_specialResult = fitWord(want_rem ? w_aExt : '1, cut);
        else
            w_specialResult = fitWord(want_rem ? '0 : w_aExt, cut);
        w_fixResult = fitWord(r_wantRem ? (r_negR ? -r_rem : r_rem)
                                        : (r_negQ ? -r_quo : r_quo), r_cut);
    end

    div_step #(.XLEN(XLEN)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_remNext (w_stepRem),
        .o_quoNext (w_stepQuo)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (flush) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: if (req) w_nextState = (w_divZero | w_overflow) ? DONE : CALC;
                CALC: if (r_count == CNT_W'(1)) w_nextState = FIX;
                FIX:  w_nextState = DONE;
                DONE: w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        done   = (r_state == DONE);
        c      = done ? r_result : '0;
        e_wait = req & (r_state != DONE) & ~flush;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_result  <= '0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_wantRem <= 1'b0;
            r_cut     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req && !flush) begin
                        r_count   <= cut ? c_wordIters : c_fullIters;
                        r_rem     <= '0;
                        r_quo     <= w_quoLoad;
                        r_div     <= w_bAbs;
                        r_negQ    <= w_aNeg ^ w_bNeg;
                        r_negR    <= w_aNeg;
                        r_wantRem <= want_rem;
                        r_cut     <= cut;
                        if (w_divZero || w_overflow) r_result <= w_specialResult;
                    end
                end
                CALC: begin
                    r_rem   <= w_stepRem;
                    r_quo   <= w_stepQuo;
                    r_count <= r_count - CNT_W'(1);
                end
                FIX: r_result <= w_fixResult;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// Module   : tb_div_ctrl
// Purpose  : Directed self-checking bench for div_ctrl (XLEN=64).
// Revision : 1.0
// =====================================================================
module tb_div_ctrl;
    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sg;
        logic        wr;
        logic        ct;
        int          lat;
        logic [63:0] expC;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, req, flush, sign, want_rem, cut;
    logic [63:0] a, b, c;
    logic        e_wait, done;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    div_ctrl #(.XLEN(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .flush    (flush),
        .a        (a),
        .b        (b),
        .sign     (sign),
        .want_rem (want_rem),
        .cut      (cut),
        .e_wait   (e_wait),
        .done     (done),
        .c        (c)
    );

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic setOp(input logic [63:0] aa, input logic [63:0] bb,
                         input logic sg, input logic wr, input logic ct);
        a = aa; b = bb; sign = sg; want_rem = wr; cut = ct; req = 1'b1;
    endtask

    // Current negedge is cycle 0 of the op; returns cycle index of done (-1 if none).
    task automatic runOp(output int lat, output logic [63:0] res,
                         output int stalls, output bit leak);
        lat = -1; res = '0; stalls = 0; leak = 1'b0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (done === 1'b1) begin
                lat = k; res = c;
                break;
            end
            if (c !== 64'd0) leak = 1'b1;
            if (e_wait === 1'b1) stalls++;
            @(negedge clk);
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 1'b0; flush = 1'b0;
        a = '0; b = '0; sign = 1'b0; want_rem = 1'b0; cut = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks += 3;
        if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        if (c !== 64'd0)     begin errors++; $display("FAIL reset_c: got %h expected 0", c); end
        if (e_wait !== 1'b0) begin errors++; $display("FAIL reset_ewait: got %b expected 0", e_wait); end
        req = 1'b1;
        #1;
        checks++;
        if (e_wait !== 1'b1) begin errors++; $display("FAIL reset_ewait_req: got %b expected 1", e_wait); end
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        vec_t v[3];
        int lat, stalls; logic [63:0] res; bit leak;
        v[0] = '{64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 66, 64'd14, "udiv_100_7"};
        v[1] = '{64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 66, 64'd2,  "urem_100_7"};
        v[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 1'b0, 1'b0, 1'b0, 66, 64'h0FFF_FFFF_FFFF_FFFF, "udiv_max_16"};
        foreach (v[i]) begin
            setOp(v[i].a, v[i].b, v[i].sg, v[i].wr, v[i].ct);
            runOp(lat, res, stalls, leak);
            checks += 3;
            if (lat !== v[i].lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat); end
            if (res !== v[i].expC) begin errors++; $display("FAIL %s result: got %h expected %h", v[i].name, res, v[i].expC); end
            if (stalls !== v[i].lat || leak) begin errors++; $display("FAIL %s stalls: got %0d (c leak %0b) expected %0d", v[i].name, stalls, leak, v[i].lat); end
        end
    endtask

    task automatic test_signed();
        vec_t v[3];
        int lat, stalls; logic [63:0] res; bit leak;
        v[0] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0, 66, 64'hFFFF_FFFF_FFFF_FFFD, "sdiv_m7_2"};
        v[1] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0, 66, 64'hFFFF_FFFF_FFFF_FFFF, "srem_m7_2"};
        v[2] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b0, 66, 64'd1, "srem_7_m2"};
        foreach (v[i]) begin
            setOp(v[i].a, v[i].b, v[i].sg, v[i].wr, v[i].ct);
            runOp(lat, res, stalls, leak);
            checks += 3;
            if (lat !== v[i].lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat); end
            if (res !== v[i].expC) begin errors++; $display("FAIL %s result: got %h expected %h", v[i].name, res, v[i].expC); end
            if (stalls !== v[i].lat || leak) begin errors++; $display("FAIL %s stalls: got %0d (c leak %0b) expected %0d", v[i].name, stalls, leak, v[i].lat); end
        end
    endtask

    task automatic test_special();
        vec_t v[5];
        int lat, stalls; logic [63:0] res; bit leak;
        v[0] = '{64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFF, "div0_q"};
        v[1] = '{64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 1, 64'd5, "div0_r"};
        v[2] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1, 64'h8000_0000_0000_0000, "ovf_q"};
        v[3] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1, 64'd0, "ovf_r"};
        v[4] = '{64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1, 64'hFFFF_FFFF_8000_0000, "ovf_word_q"};
        foreach (v[i]) begin
            setOp(v[i].a, v[i].b, v[i].sg, v[i].wr, v[i].ct);
            runOp(lat, res, stalls, leak);
            checks += 3;
            if (lat !== v[i].lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat); end
            if (res !== v[i].expC) begin errors++; $display("FAIL %s result: got %h expected %h", v[i].name, res, v[i].expC); end
            if (stalls !== v[i].lat || leak) begin errors++; $display("FAIL %s stalls: got %0d (c leak %0b) expected %0d", v[i].name, stalls, leak, v[i].lat); end
        end
    endtask

    task automatic test_word();
        vec_t v[3];
        int lat, stalls; logic [63:0] res; bit leak;
        v[0] = '{64'h0000_0001_0000_000A, 64'd3, 1'b0, 1'b0, 1'b1, 34, 64'd3, "divuw_hi_ignored"};
        v[1] = '{64'h1234_5678_FFFF_FFEC, 64'd3, 1'b1, 1'b0, 1'b1, 34, 64'hFFFF_FFFF_FFFF_FFFA, "divw_m20_3"};
        v[2] = '{64'h1234_5678_FFFF_FFEC, 64'd3, 1'b1, 1'b1, 1'b1, 34, 64'hFFFF_FFFF_FFFF_FFFE, "remw_m20_3"};
        foreach (v[i]) begin
            setOp(v[i].a, v[i].b, v[i].sg, v[i].wr, v[i].ct);
            runOp(lat, res, stalls, leak);
            checks += 3;
            if (lat !== v[i].lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat); end
            if (res !== v[i].expC) begin errors++; $display("FAIL %s result: got %h expected %h", v[i].name, res, v[i].expC); end
            if (stalls !== v[i].lat || leak) begin errors++; $display("FAIL %s stalls: got %0d (c leak %0b) expected %0d", v[i].name, stalls, leak, v[i].lat); end
        end
    endtask

    task automatic test_flush();
        int lat, stalls; logic [63:0] res; bit leak; bit early;
        // Flush together with a new req in IDLE: a started div-by-zero would finish next cycle.
        setOp(64'd5, 64'd0, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; req = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL flush_idle_req: got done=%b expected 0", done); end
        @(negedge clk);
        // Flush at CALC cycle 20; held req restarts at cycle 21, so done lands 66 cycles later.
        setOp(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
        early = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (done !== 1'b0) early = 1'b1;
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        checks += 2;
        if (e_wait !== 1'b0) begin errors++; $display("FAIL flush_ewait: got %b expected 0", e_wait); end
        if (early || done !== 1'b0) begin errors++; $display("FAIL flush_no_done: got done before flush expected none"); end
        @(negedge clk);
        flush = 1'b0;
        runOp(lat, res, stalls, leak);
        checks += 2;
        if (lat !== 66) begin errors++; $display("FAIL flush_restart_latency: got %0d expected 66", lat); end
        if (res !== 64'd14) begin errors++; $display("FAIL flush_restart_result: got %h expected %h", res, 64'd14); end
    endtask

    task automatic test_reset_mid();
        int lat, stalls; logic [63:0] res; bit leak;
        setOp(64'd100, 64'd7, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks += 2;
        if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
        if (c !== 64'd0)   begin errors++; $display("FAIL rstmid_c: got %h expected 0", c); end
        reset = 1'b1;
        runOp(lat, res, stalls, leak);
        checks += 2;
        if (lat !== 66) begin errors++; $display("FAIL rstmid_restart_latency: got %0d expected 66", lat); end
        if (res !== 64'd2) begin errors++; $display("FAIL rstmid_restart_result: got %h expected %h", res, 64'd2); end
    endtask

    task automatic test_back_to_back();
        int lat, stalls; logic [63:0] res; bit leak;
        setOp(64'd5, 64'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", done); end
        if (e_wait !== 1'b0) begin errors++; $display("FAIL b2b_done_ewait: got %b expected 0", e_wait); end
        a = 64'd100; b = 64'd7;
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || c !== 64'd0) begin errors++; $display("FAIL b2b_idle_outputs: got done=%b c=%h expected 0/0", done, c); end
        runOp(lat, res, stalls, leak);
        #1;
        checks += 3;
        if (lat !== 66) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 66", lat); end
        if (res !== 64'd14) begin errors++; $display("FAIL b2b_second_result: got %h expected %h", res, 64'd14); end
        if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_single_cycle: got %b expected 0", done); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_word();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
